// File: rtl/acc_drain_pkg.sv
// acc_drain_pkg: shared drain FSM state type for acc_drain
package acc_drain_pkg;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;
endpackage

// File: rtl/acc_drain_row_fifo.sv
// row_fifo: 2-entry row buffer with occupancy count
// Ports: clk, rstn (async active-low); push/din write a row, pop retires the head;
// dout is the head entry, count is occupancy 0..2, full/empty decode it.
// Callers never push when full nor pop when empty.
module row_fifo #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) wp_q <= !wp_q;
      if (pop) rp_q <= !rp_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= din;
  assign dout  = mem_q[rp_q];
  assign count = cnt_q;
  assign full  = cnt_q == 2'd2;
  assign empty = cnt_q == 2'd0;
endmodule

// File: rtl/acc_drain.sv
// acc_drain: buffers accumulator rows and streams them lane by lane on AXI-Stream
// Ports: clk, rstn (async active-low); s_valid/s_ready/s_data/s_last accept a row of
// R signed WY-bit lanes; m_tvalid/m_tready/m_tdata/m_tlast stream lane 0..R-1;
// overflow is sticky once a row arrives while s_ready is low.
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int R  = 8,
  parameter int WY = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [R*WY-1:0] s_data,
  input  logic          s_last,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [WY-1:0] m_tdata,
  output logic          m_tlast,
  output logic          overflow
);
  localparam int LW = (R > 1) ? $clog2(R) : 1;
  state_e        state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          ovf_q;
  logic [R*WY:0] head;
  logic [1:0]    count;
  logic          full, empty, push, pop, hs, fin;
  row_fifo #(.W(R*WY+1)) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .pop  (pop),
    .din  ({s_last, s_data}),
    .dout (head),
    .count(count),
    .full (full),
    .empty(empty)
  );
  // s_ready depends only on occupancy, so there is no combinational path from m_tready.
  assign s_ready  = !full;
  assign push     = s_valid && s_ready;
  assign m_tvalid = state_q == SEND;
  assign hs       = m_tvalid && m_tready;
  assign fin      = lane_q == LW'(R-1);
  assign pop      = hs && fin;
  assign m_tdata  = m_tvalid ? head[int'(lane_q)*WY +: WY] : '0;
  assign m_tlast  = m_tvalid && fin && head[R*WY];
  // Stay in SEND after a pop if another row remains or arrives on the same edge.
  always_comb begin
    state_d = (state_q == IDLE) ? (empty ? IDLE : SEND)
                                : ((pop && count == 2'd1 && !push) ? IDLE : SEND);
    lane_d  = !hs ? lane_q : (fin ? '0 : lane_q + 1'b1);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      lane_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      ovf_q   <= ovf_q | (s_valid && !s_ready);
    end
  assign overflow = ovf_q;
endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: randomized scoreboard bench for acc_drain
module tb_acc_drain;
  localparam int R  = 4;
  localparam int WY = 16;
  typedef struct packed {
    logic [WY-1:0] d;
    logic          l;
  } beat_t;
  logic            clk = 1'b0, rstn = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_tready = 1'b0;
  logic [R*WY-1:0] s_data = '0;
  logic            s_ready, m_tvalid, m_tlast, overflow;
  logic [WY-1:0]   m_tdata;
  beat_t           exp_q[$];
  int              total = 0, passed = 0, occ_neg = 0, prev_size = 0, sz = 0, popped = 0;
  bit              exp_ovf = 1'b0, rnd = 1'b0;
  acc_drain #(.R(R), .WY(WY)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata (m_tdata),
    .m_tlast (m_tlast),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  // Reference model: a row occupies the buffer until all its beats have been handshaken.
  always @(negedge rstn) begin
    exp_q.delete();
    exp_ovf   = 1'b0;
    occ_neg   = 0;
    prev_size = 0;
  end
  always @(posedge clk)
    if (rstn && s_valid) begin
      if (occ_neg < 2)
        for (int i = 0; i < R; i++) exp_q.push_back({s_data[i*WY +: WY], s_last && (i == R-1)});
      else exp_ovf = 1'b1;
    end
  always @(posedge clk) begin
    #1;
    if (rnd) m_tready = 1'($urandom % 2);
  end
  always @(negedge clk)
    if (rstn) begin
      sz      = exp_q.size();
      occ_neg = (sz + R - 1) / R;
      chk("s_ready", 32'(s_ready), 32'(occ_neg < 2));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      if (sz == 0) chk("idle_valid", 32'(m_tvalid), 32'd0);
      else begin
        if (prev_size > 0) chk("no_bubble", 32'(m_tvalid), 32'd1);
        if (m_tvalid) begin
          chk("tdata", 32'(m_tdata), 32'(exp_q[0].d));
          chk("tlast", 32'(m_tlast), 32'(exp_q[0].l));
          if (m_tready) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      prev_size = exp_q.size();
    end
  task automatic send_row(input logic [R*WY-1:0] d, input logic l);
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask
  task automatic drain(input int maxc);
    int n = 0;
    while ((exp_q.size() > 0 || m_tvalid) && n < maxc) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask
  task automatic wait_size(input int s);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (exp_q.size() != s && n < 50);
    chk("wait_size", 32'(exp_q.size()), 32'(s));
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask
  function automatic logic [WY-1:0] pick();
    case ($urandom % 5)
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return WY'($urandom);
    endcase
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [R*WY-1:0] row;
    int sent, it, base;
    #12;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    m_tready = 1'b1;
    send_row({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b1);
    drain(50);
    m_tready = 1'b0;
    base = popped;
    send_row({16'h1004, 16'h1003, 16'h1002, 16'h1001}, 1'b0);
    send_row({16'h2004, 16'h2003, 16'h2002, 16'h2001}, 1'b1);
    send_row({16'h3004, 16'h3003, 16'h3002, 16'h3001}, 1'b1);
    @(negedge clk); #1;
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_sready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    m_tready = 1'b1;
    drain(100);
    chk("held_beats", 32'(popped - base), 32'd8);
    do_reset();
    rnd  = 1'b1;
    sent = 0;
    it   = 0;
    while (sent < 100 && it < 5000) begin
      if (s_ready && ($urandom % 4 != 0)) begin
        for (int i = 0; i < R; i++) row[i*WY +: WY] = pick();
        s_data  = row;
        s_last  = 1'($urandom % 2);
        s_valid = 1'b1;
        sent++;
      end else s_valid = 1'b0;
      @(posedge clk); #1;
      it++;
    end
    s_valid = 1'b0;
    chk("rand_sent", 32'(sent), 32'd100);
    drain(3000);
    rnd = 1'b0;
    @(posedge clk); #1;
    do_reset();
    m_tready = 1'b0;
    send_row({16'h4004, 16'h4003, 16'h4002, 16'h4001}, 1'b0);
    send_row({16'h5004, 16'h5003, 16'h5002, 16'h5001}, 1'b1);
    m_tready = 1'b1;
    wait_size(R);
    s_data  = {16'h6004, 16'h6003, 16'h6002, 16'h6001};
    s_last  = 1'b1;
    s_valid = 1'b1;
    @(posedge clk); #1;
    send_row({16'h7004, 16'h7003, 16'h7002, 16'h7001}, 1'b1);
    chk("edge_ovf", 32'(overflow), 32'd1);
    drain(100);
    do_reset();
    m_tready = 1'b1;
    send_row({16'h8004, 16'h8003, 16'h8002, 16'h8001}, 1'b1);
    wait_size(R - 3);
    rstn = 1'b0;
    #1;
    chk("async_tvalid", 32'(m_tvalid), 32'd0);
    chk("async_tdata", 32'(m_tdata), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    send_row({16'h9004, 16'h9003, 16'h9002, 16'h9001}, 1'b1);
    drain(50);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
